// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types and widths for the register-file write-port arbiter and its
// MDU result queue.
package rf_wport_arbiter_pkg;
    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam int QMAX  = 4;

    typedef struct packed {
        logic             valid;
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } rfarb_entry_t;
endpackage

// File: rtl/rf_wport_arbiter_queue.sv
// rfarb_queue: DEPTH-entry circular buffer of MDU results with kill-by-address,
// skip-over-killed head lookup and a two-address pending-match port.
module rfarb_queue
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_en,
    input  logic [RF_AW-1:0] push_addr,
    input  logic [RF_DW-1:0] push_data,
    input  logic             pop_en,
    input  logic             kill_en,
    input  logic [RF_AW-1:0] kill_addr,
    input  logic [RF_AW-1:0] look_a,
    input  logic [RF_AW-1:0] look_b,
    output rfarb_entry_t     head,
    output logic [2:0]       count,
    output logic             hit_a,
    output logic             hit_b
);
    rfarb_entry_t mem_q [QMAX];
    rfarb_entry_t mem_d [QMAX];
    logic [1:0]   head_q, head_d, tail_q, tail_d;
    logic [2:0]   count_q, count_d;
    logic [2:0]   drain_n;
    logic [1:0]   scan_idx, pop_idx;
    logic         found;

    function automatic logic [1:0] wrap(input logic [3:0] p);
        if (p >= 4'(DEPTH)) return 2'(p - 4'(DEPTH));
        return p[1:0];
    endfunction

    // Head is the oldest still-valid entry; drain_n counts it plus any killed
    // entries in front of it (or every entry when all of them are killed).
    always_comb begin
        head     = '0;
        drain_n  = count_q;
        found    = 1'b0;
        scan_idx = '0;
        hit_a    = 1'b0;
        hit_b    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = wrap({2'b00, head_q} + 4'(i));
            if (!found && (3'(i) < count_q) && mem_q[scan_idx].valid) begin
                head    = mem_q[scan_idx];
                drain_n = 3'(i + 1);
                found   = 1'b1;
            end
            if (mem_q[i].valid && (mem_q[i].addr == look_a)) hit_a = 1'b1;
            if (mem_q[i].valid && (mem_q[i].addr == look_b)) hit_b = 1'b1;
        end
    end

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_idx = '0;
        if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_d[i].valid && (mem_d[i].addr == kill_addr)) mem_d[i].valid = 1'b0;
            end
        end
        if (pop_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                pop_idx = wrap({2'b00, head_q} + 4'(i));
                if (3'(i) < drain_n) mem_d[pop_idx].valid = 1'b0;
            end
            head_d  = wrap({2'b00, head_q} + {1'b0, drain_n});
            count_d = count_q - drain_n;
        end
        // A push lands after the pop so a full queue can refill the freed slot.
        if (push_en) begin
            mem_d[tail_q] = '{valid: 1'b1, addr: push_addr, data: push_data};
            tail_d        = wrap({2'b00, tail_q} + 4'd1);
            count_d       = count_d + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QMAX; i++) mem_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the register-file write port between MEM/WB writeback and the MDU.
// Optional starvation guard (WB_HOLD) is enabled by defining RFARB_STARVE_EN.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             WB_REGWRITE,
    input  logic [RF_AW-1:0] WB_ADDR,
    input  logic [RF_DW-1:0] WB_DATA,
    input  logic             MDU_VALID,
    input  logic [RF_AW-1:0] MDU_ADDR,
    input  logic [RF_DW-1:0] MDU_DATA,
    output logic             MDU_READY,
    input  logic [RF_AW-1:0] ID_RS,
    input  logic [RF_AW-1:0] ID_RT,
    output logic             PEND_RS_HIT,
    output logic             PEND_RT_HIT,
    output logic             WB_HOLD,
    output logic             RF_WR,
    output logic [RF_AW-1:0] RF_ADDR,
    output logic [RF_DW-1:0] RF_DATA
);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    rfarb_entry_t q_head;
    logic [2:0]   q_count;
    logic         q_hit_rs, q_hit_rt;
    logic         pop_en, mdu_accept, bypass, push_en, kill_en, rf_wr_raw;

    rfarb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (CLOCK),
        .reset     (RESET),
        .push_en   (push_en),
        .push_addr (MDU_ADDR),
        .push_data (MDU_DATA),
        .pop_en    (pop_en),
        .kill_en   (kill_en),
        .kill_addr (WB_ADDR),
        .look_a    (ID_RS),
        .look_b    (ID_RT),
        .head      (q_head),
        .count     (q_count),
        .hit_a     (q_hit_rs),
        .hit_b     (q_hit_rt)
    );

    // Any idle-WB cycle with a non-empty queue drains at least one slot, so
    // the MDU may be accepted even when the queue is full.
    always_comb begin
        pop_en     = !RESET && !WB_REGWRITE && (q_count != 3'd0);
        MDU_READY  = !RESET && ((q_count < DEPTH_C) || pop_en);
        mdu_accept = MDU_VALID && MDU_READY;
        bypass     = mdu_accept && !WB_REGWRITE && !q_head.valid;
        push_en    = mdu_accept && !bypass && (MDU_ADDR != '0);
        kill_en    = !RESET && WB_REGWRITE && (WB_ADDR != '0);
    end

    always_comb begin
        rf_wr_raw = 1'b0;
        RF_ADDR   = WB_ADDR;
        RF_DATA   = WB_DATA;
        if (WB_REGWRITE) begin
            rf_wr_raw = 1'b1;
        end else if (q_head.valid) begin
            rf_wr_raw = 1'b1;
            RF_ADDR   = q_head.addr;
            RF_DATA   = q_head.data;
        end else if (mdu_accept) begin
            rf_wr_raw = 1'b1;
            RF_ADDR   = MDU_ADDR;
            RF_DATA   = MDU_DATA;
        end
        RF_WR = rf_wr_raw && !RESET && (RF_ADDR != '0);
    end

    always_comb begin
        PEND_RS_HIT = !RESET && (ID_RS != '0) && (q_hit_rs || (push_en && (MDU_ADDR == ID_RS)));
        PEND_RT_HIT = !RESET && (ID_RT != '0) && (q_hit_rt || (push_en && (MDU_ADDR == ID_RT)));
    end

`ifdef RFARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;
    logic       hold_q, hold_d;

    // Counter saturates at the limit so WB_HOLD stays up until the next pop.
    always_comb begin
        starve_d = starve_q;
        hold_d   = hold_q;
        if (pop_en || (q_count == 3'd0)) begin
            starve_d = '0;
            hold_d   = 1'b0;
        end else if (WB_REGWRITE) begin
            if (starve_q < STARVE_LIM) starve_d = starve_q + 4'd1;
            hold_d = hold_q || (starve_d >= STARVE_LIM);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            starve_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            starve_q <= starve_d;
            hold_q   <= hold_d;
        end
    end

    assign WB_HOLD = hold_q;
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_MAX == 0);
    assign WB_HOLD = 1'b0;
`endif
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter (DEPTH=2, STARVE_MAX=4): a table of
// per-cycle vectors plus hand-written starvation and mid-operation reset runs.
module tb_rf_wport_arbiter;

   typedef struct {
      logic        rst, we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        mv;
      logic [4:0]  ma;
      logic [31:0] md;
      logic [4:0]  rs, rt;
      logic        eWr;
      logic [4:0]  eAddr;
      logic [31:0] eData;
      logic        eRdy, eHrs, eHrt, eHold;
   } vec_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

`ifdef RFARB_STARVE_EN
   localparam int STARVE_ON = 1;
`else
   localparam int STARVE_ON = 0;
`endif

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        WB_REGWRITE;
   logic [4:0]  WB_ADDR;
   logic [31:0] WB_DATA;
   logic        MDU_VALID;
   logic [4:0]  MDU_ADDR;
   logic [31:0] MDU_DATA;
   logic        MDU_READY;
   logic [4:0]  ID_RS, ID_RT;
   logic        PEND_RS_HIT, PEND_RT_HIT, WB_HOLD;
   logic        RF_WR;
   logic [4:0]  RF_ADDR;
   logic [31:0] RF_DATA;

   int          errors = 0;
   int          checks = 0;
   vec_t        vecs[$];
   wr_t         sbQ[$];
   logic [31:0] rfModel [32];

   rf_wport_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .WB_REGWRITE (WB_REGWRITE),
      .WB_ADDR     (WB_ADDR),
      .WB_DATA     (WB_DATA),
      .MDU_VALID   (MDU_VALID),
      .MDU_ADDR    (MDU_ADDR),
      .MDU_DATA    (MDU_DATA),
      .MDU_READY   (MDU_READY),
      .ID_RS       (ID_RS),
      .ID_RT       (ID_RT),
      .PEND_RS_HIT (PEND_RS_HIT),
      .PEND_RT_HIT (PEND_RT_HIT),
      .WB_HOLD     (WB_HOLD),
      .RF_WR       (RF_WR),
      .RF_ADDR     (RF_ADDR),
      .RF_DATA     (RF_DATA)
   );

   // Free-running clock, 10 time units per cycle
   always #5 CLOCK = ~CLOCK;

   // Register file as seen through the write port, for end-state checks
   always @(posedge CLOCK) begin
      if (RF_WR === 1'b1) rfModel[RF_ADDR] <= RF_DATA;
   end

   // Hard stop in case the bench ever wedges
   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input int rst, input int we, input int wa, input logic [31:0] wd,
                               input int mv, input int ma, input logic [31:0] md, input int rs, input int rt,
                               input int eWr, input int eAddr, input logic [31:0] eData,
                               input int eRdy, input int eHrs, input int eHrt, input int eHold);
      vec_t v;
      v.rst = 1'(rst);   v.we = 1'(we);   v.wa = 5'(wa);   v.wd = wd;
      v.mv = 1'(mv);     v.ma = 5'(ma);   v.md = md;
      v.rs = 5'(rs);     v.rt = 5'(rt);
      v.eWr = 1'(eWr);   v.eAddr = 5'(eAddr); v.eData = eData;
      v.eRdy = 1'(eRdy); v.eHrs = 1'(eHrs); v.eHrt = 1'(eHrt); v.eHold = 1'(eHold);
      return v;
   endfunction

   // One named comparison; counts it and reports on mismatch
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the write that cycle should produce
   task automatic applyStimulus(input vec_t v);
      wr_t w;
      RESET       = v.rst;
      WB_REGWRITE = v.we;
      WB_ADDR     = v.wa;
      WB_DATA     = v.wd;
      MDU_VALID   = v.mv;
      MDU_ADDR    = v.ma;
      MDU_DATA    = v.md;
      ID_RS       = v.rs;
      ID_RT       = v.rt;
      if (v.eWr) begin
         w.addr = v.eAddr;
         w.data = v.eData;
         sbQ.push_back(w);
      end
   endtask

   // Compare combinational outputs and pop the scoreboard on a write
   task automatic checkOutput(input vec_t v, input string tag);
      wr_t w;
      chk({tag, " RF_WR"}, 32'(RF_WR), 32'(v.eWr));
      chk({tag, " MDU_READY"}, 32'(MDU_READY), 32'(v.eRdy));
      chk({tag, " PEND_RS_HIT"}, 32'(PEND_RS_HIT), 32'(v.eHrs));
      chk({tag, " PEND_RT_HIT"}, 32'(PEND_RT_HIT), 32'(v.eHrt));
      chk({tag, " WB_HOLD"}, 32'(WB_HOLD), 32'(v.eHold));
      if (RF_WR === 1'b1) begin
         if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s unexpected write actual addr=%0d data=%h required=none", tag, RF_ADDR, RF_DATA);
         end else begin
            w = sbQ.pop_front();
            chk({tag, " RF_ADDR"}, 32'(RF_ADDR), 32'(w.addr));
            chk({tag, " RF_DATA"}, RF_DATA, w.data);
         end
      end else if (v.eWr && sbQ.size() > 0) begin
         void'(sbQ.pop_front());
      end
   endtask

   task automatic runRow(input vec_t v, input string tag);
      applyStimulus(v);
      @(negedge CLOCK);
      checkOutput(v, tag);
      @(posedge CLOCK);
      #1;
   endtask

   // Queue one result, keep WB busy until WB_HOLD rises, then release WB
   task automatic runStarve();
      int h;
      h = STARVE_ON;
      runRow(mk(0,1,1,'h51, 1,12,'hC12, 12,0, 1,1,'h51, 1,1,0,0), "starve0");
      runRow(mk(0,1,2,'h52, 0,0,0, 12,0, 1,2,'h52, 1,1,0,0), "starve1");
      runRow(mk(0,1,3,'h53, 0,0,0, 12,0, 1,3,'h53, 1,1,0,0), "starve2");
      runRow(mk(0,1,4,'h54, 0,0,0, 12,0, 1,4,'h54, 1,1,0,0), "starve3");
      runRow(mk(0,1,5,'h55, 0,0,0, 12,0, 1,5,'h55, 1,1,0,0), "starve4");
      runRow(mk(0,1,6,'h56, 0,0,0, 12,0, 1,6,'h56, 1,1,0,h), "starve5");
      runRow(mk(0,0,0,0, 0,0,0, 12,0, 1,12,'hC12, 1,1,0,h), "starve6");
      runRow(mk(0,0,0,0, 0,0,0, 12,0, 0,0,0, 1,0,0,0), "starve7");
      chk("rf12 written", rfModel[12], 32'hC12);
   endtask

   // Two queued results are discarded by a reset and never written
   task automatic runResetMid();
      runRow(mk(0,1,1,'h61, 1,13,'hD13, 13,0, 1,1,'h61, 1,1,0,0), "rstmid0");
      runRow(mk(0,1,2,'h62, 1,14,'hD14, 13,14, 1,2,'h62, 1,1,1,0), "rstmid1");
      runRow(mk(1,0,0,0, 0,0,0, 13,14, 0,0,0, 0,0,0,0), "rstmid2");
      runRow(mk(0,0,0,0, 0,0,0, 13,14, 0,0,0, 1,0,0,0), "rstmid3");
      runRow(mk(0,0,0,0, 0,0,0, 13,14, 0,0,0, 1,0,0,0), "rstmid4");
   endtask

   initial begin
      // Reset
      vecs.push_back(mk(1,0,0,0, 1,5,'h5, 5,5, 0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0));
      // Bypass to address 5
      vecs.push_back(mk(0,0,0,0, 1,5,'hDEAD0005, 5,0, 1,5,'hDEAD0005, 1,0,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0, 5,0, 0,0,0, 1,0,0,0));
      // WB busy: 7 and 8 queued, third offer refused, then drained in order
      vecs.push_back(mk(0,1,1,'h100, 1,7,'h7007, 7,8, 1,1,'h100, 1,1,0,0));
      vecs.push_back(mk(0,1,2,'h200, 1,8,'h8008, 7,8, 1,2,'h200, 1,1,1,0));
      vecs.push_back(mk(0,1,3,'h300, 1,9,'h9009, 7,8, 1,3,'h300, 0,1,1,0));
      vecs.push_back(mk(0,0,0,0, 1,9,'h9009, 7,8, 1,7,'h7007, 1,1,1,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0, 7,8, 1,8,'h8008, 1,0,1,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0, 9,8, 1,9,'h9009, 1,1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0, 9,0, 0,0,0, 1,0,0,0));
      // WAW kill of a queued 9
      vecs.push_back(mk(0,1,4,'h400, 1,9,'h11, 9,0, 1,4,'h400, 1,1,0,0));
      vecs.push_back(mk(0,1,9,'h22, 0,0,0, 9,0, 1,9,'h22, 1,1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0, 9,0, 0,0,0, 1,0,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0, 9,0, 0,0,0, 1,0,0,0));
      // Killed head skipped, next valid entry written in the same cycle
      vecs.push_back(mk(0,1,1,'hA1, 1,10,'hAA, 10,0, 1,1,'hA1, 1,1,0,0));
      vecs.push_back(mk(0,1,2,'hA2, 1,11,'hBB, 10,11, 1,2,'hA2, 1,1,1,0));
      vecs.push_back(mk(0,1,10,'hCC, 0,0,0, 10,11, 1,10,'hCC, 0,1,1,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0, 10,11, 1,11,'hBB, 1,0,1,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0, 11,0, 0,0,0, 1,0,0,0));
      // Address 0 from MDU and from WB
      vecs.push_back(mk(0,0,0,0, 1,0,'h1234, 0,0, 0,0,0, 1,0,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,0,0));
      vecs.push_back(mk(0,1,0,'h5, 0,0,0, 0,0, 0,0,0, 1,0,0,0));

      RESET = 1'b1;
      WB_REGWRITE = 1'b0; WB_ADDR = '0; WB_DATA = '0;
      MDU_VALID = 1'b0;   MDU_ADDR = '0; MDU_DATA = '0;
      ID_RS = '0; ID_RT = '0;

      for (int i = 0; i < vecs.size(); i++) begin
         runRow(vecs[i], $sformatf("row%0d", i));
      end
      chk("rf9 retains WB value", rfModel[9], 32'h22);

      runStarve();
      runResetMid();

      chk("scoreboard drained", 32'(sbQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
